rr_interval_binner: RTL
=======================

# rr_interval_binner

Front-end stage of the RR-interval histogram path. It watches a beat-detector R-peak strobe and measures the time between consecutive accepted peaks in prescaled ticks. It applies a refractory blanking window and a timeout, then quantises each interval into a 10-bit bin index. Each bin index is issued as a one-cycle valid pulse to the probability-distribution (histogram) stage, which increments that bin only when `bin_valid` is high.

## Interface
Parameters:
- `TICK_DIV`, 1000: clock cycles per timer tick, ≥2.
- `BIN_SHIFT`, 0: right shift applied to the tick count to form the bin.
- `REFRACT_TICKS`, 200: ticks after a peak during which new peaks are ignored, ≥1.
- `MAX_TICKS`, 2000: interval timeout in ticks, > `REFRACT_TICKS`, < 65535.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  measurement enable; low forces IDLE.
- `r_peak`  in  1  R-peak indication, synchronous to `clk`; only rising edges count.
- `bin_index`  out  10  quantised interval, held until the next `bin_valid`.
- `bin_valid`  out  1  one-cycle strobe; `bin_index` is valid in this cycle.
- `interval_ticks`  out  16  raw tick count of the last emitted interval.
- `peak_rejected`  out  1  one-cycle strobe: edge fell inside the refractory window.
- `timeout`  out  1  one-cycle strobe: `MAX_TICKS` reached without an accepted peak.
- `state`  out  2  current FSM state: 0 IDLE, 1 REFRACT, 2 ARMED.

## Operation
- Edge detect: `r_q` registers `r_peak`. Edge = `r_peak & ~r_q`.
- Prescaler `pre` counts 0..`TICK_DIV`-1. `tick` is asserted when `pre == TICK_DIV-1`, and `pre` wraps to 0. Tick counter `tcnt` (16 bit) increments on `tick` and saturates at 65535.
- An accepted or starting peak clears `pre` and `tcnt` to 0 in the same cycle.
- FSM:
  - IDLE: on edge, clear counters and go to REFRACT. Nothing is emitted; the first peak only starts timing.
  - REFRACT: when `tcnt == REFRACT_TICKS`, go to ARMED. An edge here pulses `peak_rejected`, does not clear counters, and the state stays REFRACT.
  - ARMED: on edge, emit the interval, clear counters, and go to REFRACT.
  - REFRACT or ARMED: when `tcnt == MAX_TICKS` with no edge, pulse `timeout` and go to IDLE. Nothing is emitted.
- Emit, registered on the edge cycle:
  - `interval_ticks <= tcnt` (the pre-clear value).
  - `bin_index <= min(tcnt >> BIN_SHIFT, 1023)`.
  - `bin_valid <= 1` for exactly one cycle.
- Simultaneous edge and `tcnt == MAX_TICKS` in ARMED: the edge wins. The interval is emitted and `timeout` is not asserted.
- Simultaneous edge and the REFRACT→ARMED transition: the peak is rejected and the state moves to ARMED.
- `enable` low: state goes to IDLE next cycle. `pre` and `tcnt` are held at 0, all strobes stay 0, and `bin_index`/`interval_ticks` keep their last values. Edges are ignored, but `r_q` keeps tracking `r_peak`.
- Reset mid-measurement discards the partial interval. No strobe is produced.

## Timing
- Reset values: `bin_index` 0, `bin_valid` 0, `interval_ticks` 0, `peak_rejected` 0, `timeout` 0, `state` IDLE. Internal `r_q`, `pre` and `tcnt` also reset to 0.
- Latency: `r_peak` rising at clock edge N (sampled high at N, low at N-1) produces `bin_valid` high in cycle N+1 only.
- Measured interval: `floor(D / TICK_DIV)`, where D is the cycle distance between the two accepted edges.
- Throughput: at most one emission per `REFRACT_TICKS*TICK_DIV` cycles. No back-pressure; the downstream stage must accept every strobe.
- Strobes are mutually exclusive in any cycle.
- `state` reflects the registered FSM state.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `BIN_SHIFT`=0, `REFRACT_TICKS`=3, `MAX_TICKS`=50.
- Reset and first peak: release `rst_n`, hold `enable`=1, pulse `r_peak` at cycle 10 → no `bin_valid`, `state` goes to REFRACT at cycle 11, and all outputs are 0 before that.
- Normal interval: edges at cycles 10 and 90 → one `bin_valid` at cycle 91 with `bin_index`=20 and `interval_ticks`=20. Edges at 90 and 134 → `bin_index`=11.
- Refractory rejection: edges at 10, 18 and 90 → `peak_rejected` at cycle 19 and `bin_valid` at cycle 91 with `bin_index`=20.
- Timeout: edge at 10 with no further edge → `timeout` pulses once when `tcnt` reaches 50 and `state` returns to IDLE. A later edge restarts timing without emitting.
- Clamp and shift: `BIN_SHIFT`=0, `MAX_TICKS`=2000, edges 1100 ticks apart → `bin_index`=1023 and `interval_ticks`=1100. With `BIN_SHIFT`=1 → `bin_index`=550.
- Mid-operation disruption: in ARMED, assert `rst_n`=0 for 2 cycles, or drop `enable` for 1 cycle → no strobes, `state` IDLE, and the next edge only restarts timing.

Source files
------------

// File: rtl/rr_interval_binner.sv
// rtl/rr_interval_binner.sv - R-peak interval timer with refractory/timeout and 10-bit bin quantiser
module rr_interval_binner #(
    parameter int TICK_DIV      = 1000,
    parameter int BIN_SHIFT     = 0,
    parameter int REFRACT_TICKS = 200,
    parameter int MAX_TICKS     = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        r_peak,
    output logic [9:0]  bin_index,
    output logic        bin_valid,
    output logic [15:0] interval_ticks,
    output logic        peak_rejected,
    output logic        timeout,
    output logic [1:0]  state
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t        st;
    logic          r_q;
    logic [PW-1:0] pre;
    logic [15:0]   tcnt;
    logic          pk_edge;
    logic          tick;
    logic [15:0]   tcnt_inc;
    logic [15:0]   shifted;
    logic [9:0]    bin_calc;

    assign pk_edge = r_peak & ~r_q;
    assign tick    = (pre == PW'(TICK_DIV - 1));

    // Emitted interval includes a tick landing on the edge cycle, so it equals floor(D/TICK_DIV).
    assign tcnt_inc = (tick && tcnt != 16'hFFFF) ? tcnt + 16'd1 : tcnt;
    assign shifted  = tcnt_inc >> BIN_SHIFT;
    assign bin_calc = (shifted > 16'd1023) ? 10'd1023 : shifted[9:0];
    assign state    = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st             <= IDLE;
            r_q            <= 1'b0;
            pre            <= '0;
            tcnt           <= '0;
            bin_index      <= '0;
            bin_valid      <= 1'b0;
            interval_ticks <= '0;
            peak_rejected  <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            r_q           <= r_peak;
            bin_valid     <= 1'b0;
            peak_rejected <= 1'b0;
            timeout       <= 1'b0;
            if (!enable) begin
                st   <= IDLE;
                pre  <= '0;
                tcnt <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        pre  <= '0;
                        tcnt <= '0;
                        if (pk_edge) st <= REFRACT;
                    end
                    REFRACT: begin
                        pre  <= tick ? '0 : pre + PW'(1);
                        tcnt <= tcnt_inc;
                        if (pk_edge) peak_rejected <= 1'b1;
                        if (!pk_edge && tcnt == 16'(MAX_TICKS)) begin
                            timeout <= 1'b1;
                            st      <= IDLE;
                            pre     <= '0;
                            tcnt    <= '0;
                        end else if (tcnt == 16'(REFRACT_TICKS)) begin
                            st <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (pk_edge) begin
                            interval_ticks <= tcnt_inc;
                            bin_index      <= bin_calc;
                            bin_valid      <= 1'b1;
                            pre            <= '0;
                            tcnt           <= '0;
                            st             <= REFRACT;
                        end else if (tcnt == 16'(MAX_TICKS)) begin
                            timeout <= 1'b1;
                            pre     <= '0;
                            tcnt    <= '0;
                            st      <= IDLE;
                        end else begin
                            pre  <= tick ? '0 : pre + PW'(1);
                            tcnt <= tcnt_inc;
                        end
                    end
                    default: begin
                        st   <= IDLE;
                        pre  <= '0;
                        tcnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule
